// File: rtl/mult_div_rs.sv
// mult_div_rs: reservation station in front of an RV32M multiply/divide unit.
// It holds up to RS_DEPTH dispatched instructions. Operands that are not ready
// are woken up by CDB broadcasts. The oldest ready entry is issued whenever the
// unit is idle or is completing its current operation.
//
// Parameters: RS_DEPTH (entries, 2..8), ROB_DEPTH (TAGW = $clog2(ROB_DEPTH)).
// Ports:
//   clk, rst (sync, active-high), flush         - clock, reset, squash waiting entries
//   dispatch_*, rs1_*/rs2_* (ready/tag/data)    - dispatch request and operands
//   rs_full                                     - all entries occupied (combinational)
//   cdb_valid/cdb_tag/cdb_data                  - result broadcast bus
//   mult_div_instr_in, rs1_v, rs2_v, rob_tag    - registered issue payload, held until next issue
//   mult_div_en                                 - one-cycle issue strobe
//   mult_div_resp                               - unit finished its operation
// Build option: define MDRS_CDB_ISSUE_BYPASS_EN to let an entry issue in the same
// cycle that the CDB supplies its last missing operand.
module mult_div_rs #(
  parameter int RS_DEPTH  = 4,
  parameter int ROB_DEPTH = 8,
  localparam int TAGW     = $clog2(ROB_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            dispatch_valid,
  input  logic [31:0]     dispatch_instr,
  input  logic [TAGW-1:0] dispatch_rob_tag,
  input  logic            rs1_ready,
  input  logic            rs2_ready,
  input  logic [TAGW-1:0] rs1_tag,
  input  logic [TAGW-1:0] rs2_tag,
  input  logic [31:0]     rs1_data,
  input  logic [31:0]     rs2_data,
  output logic            rs_full,
  input  logic            cdb_valid,
  input  logic [TAGW-1:0] cdb_tag,
  input  logic [31:0]     cdb_data,
  output logic [31:0]     mult_div_instr_in,
  output logic [31:0]     rs1_v,
  output logic [31:0]     rs2_v,
  output logic [TAGW-1:0] rob_tag,
  output logic            mult_div_en,
  input  logic            mult_div_resp
);
  localparam int IDXW = $clog2(RS_DEPTH);

  logic [RS_DEPTH-1:0] valid, r1, r2;
  logic [31:0]         instr [RS_DEPTH];
  logic [31:0]         v1    [RS_DEPTH];
  logic [31:0]         v2    [RS_DEPTH];
  logic [TAGW-1:0]     dtag  [RS_DEPTH];
  logic [TAGW-1:0]     t1    [RS_DEPTH];
  logic [TAGW-1:0]     t2    [RS_DEPTH];
  // older[i][j] = 1 when entry i was dispatched before entry j.
  logic [RS_DEPTH-1:0] older [RS_DEPTH];
  logic                busy;

  logic [RS_DEPTH-1:0] hit1, hit2, elig, oldest;
  logic                free_found, do_issue, do_dispatch;
  logic [IDXW-1:0]     free_idx, iss_idx;
  logic [31:0]         iss_v1, iss_v2;
  logic                d1_rdy, d2_rdy;
  logic [31:0]         d1_val, d2_val;

  assign rs_full = &valid;

  always_comb begin
    hit1       = '0;
    hit2       = '0;
    elig       = '0;
    oldest     = '0;
    free_found = 1'b0;
    free_idx   = '0;
    iss_idx    = '0;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      hit1[i] = cdb_valid && valid[i] && !r1[i] && (t1[i] == cdb_tag);
      hit2[i] = cdb_valid && valid[i] && !r2[i] && (t2[i] == cdb_tag);
`ifdef MDRS_CDB_ISSUE_BYPASS_EN
      elig[i] = valid[i] && (r1[i] || hit1[i]) && (r2[i] || hit2[i]);
`else
      elig[i] = valid[i] && r1[i] && r2[i];
`endif
      if (!valid[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDXW'(i);
      end
    end
    // An eligible entry is oldest when no other eligible entry predates it.
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      oldest[i] = elig[i];
      for (int unsigned j = 0; j < RS_DEPTH; j++)
        if (j != i && elig[j] && older[j][i]) oldest[i] = 1'b0;
    end
    for (int unsigned i = 0; i < RS_DEPTH; i++)
      if (oldest[i]) iss_idx = IDXW'(i);

    do_issue    = (|elig) && (!busy || mult_div_resp) && !flush;
    do_dispatch = dispatch_valid && !rs_full && !flush;

    iss_v1 = v1[iss_idx];
    iss_v2 = v2[iss_idx];
`ifdef MDRS_CDB_ISSUE_BYPASS_EN
    if (hit1[iss_idx]) iss_v1 = cdb_data;
    if (hit2[iss_idx]) iss_v2 = cdb_data;
`endif

    d1_rdy = rs1_ready || (cdb_valid && (cdb_tag == rs1_tag));
    d2_rdy = rs2_ready || (cdb_valid && (cdb_tag == rs2_tag));
    d1_val = rs1_ready ? rs1_data : cdb_data;
    d2_val = rs2_ready ? rs2_data : cdb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid             <= '0;
      busy              <= 1'b0;
      mult_div_en       <= 1'b0;
      mult_div_instr_in <= '0;
      rs1_v             <= '0;
      rs2_v             <= '0;
      rob_tag           <= '0;
    end else begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
        if (hit1[i]) begin
          r1[i] <= 1'b1;
          v1[i] <= cdb_data;
        end
        if (hit2[i]) begin
          r2[i] <= 1'b1;
          v2[i] <= cdb_data;
        end
      end

      mult_div_en <= do_issue;
      if (do_issue) begin
        valid[iss_idx]    <= 1'b0;
        mult_div_instr_in <= instr[iss_idx];
        rs1_v             <= iss_v1;
        rs2_v             <= iss_v2;
        rob_tag           <= dtag[iss_idx];
        busy              <= 1'b1;
      end else if (mult_div_resp) begin
        busy <= 1'b0;
      end

      // The free slot is never the issuing slot, so both may update together.
      if (do_dispatch) begin
        valid[free_idx] <= 1'b1;
        instr[free_idx] <= dispatch_instr;
        dtag[free_idx]  <= dispatch_rob_tag;
        r1[free_idx]    <= d1_rdy;
        t1[free_idx]    <= rs1_tag;
        v1[free_idx]    <= d1_val;
        r2[free_idx]    <= d2_rdy;
        t2[free_idx]    <= rs2_tag;
        v2[free_idx]    <= d2_val;
        for (int unsigned j = 0; j < RS_DEPTH; j++) begin
          older[free_idx][j] <= 1'b0;
          if (j != 32'(free_idx)) older[j][free_idx] <= 1'b1;
        end
      end

      if (flush) valid <= '0;
    end
  end
endmodule

// File: tb/tb_mult_div_rs.sv
// Directed self-checking bench for mult_div_rs (RS_DEPTH=4, ROB_DEPTH=8).
module tb_mult_div_rs;
  logic        clk = 1'b0;
  logic        rst, flush, dispatch_valid;
  logic [31:0] dispatch_instr;
  logic [2:0]  dispatch_rob_tag;
  logic        rs1_ready, rs2_ready;
  logic [2:0]  rs1_tag, rs2_tag;
  logic [31:0] rs1_data, rs2_data;
  logic        rs_full;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [31:0] mult_div_instr_in, rs1_v, rs2_v;
  logic [2:0]  rob_tag;
  logic        mult_div_en, mult_div_resp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult_div_rs #(.RS_DEPTH(4), .ROB_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_instr(dispatch_instr),
    .dispatch_rob_tag(dispatch_rob_tag),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs_full(rs_full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .mult_div_instr_in(mult_div_instr_in), .rs1_v(rs1_v), .rs2_v(rs2_v),
    .rob_tag(rob_tag), .mult_div_en(mult_div_en), .mult_div_resp(mult_div_resp)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch_one(input logic [31:0] ins, input logic [2:0] tag,
                              input logic r1, input logic [2:0] tg1, input logic [31:0] d1,
                              input logic r2, input logic [2:0] tg2, input logic [31:0] d2);
    dispatch_valid   = 1'b1;
    dispatch_instr   = ins;
    dispatch_rob_tag = tag;
    rs1_ready = r1; rs1_tag = tg1; rs1_data = d1;
    rs2_ready = r2; rs2_tag = tg2; rs2_data = d2;
    step();
    dispatch_valid = 1'b0;
  endtask

  task automatic pulse_resp();
    mult_div_resp = 1'b1;
    step();
    mult_div_resp = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dispatch_valid = 1'b1;
    step();
    step();
    rst = 1'b0;
    dispatch_valid = 1'b0;
    n_checks++; if (mult_div_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", mult_div_en); end
    n_checks++; if (rs_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", rs_full); end
    n_checks++; if (rob_tag !== 3'd0) begin n_fail++; $display("FAIL reset_tag: got %0d expected 0", rob_tag); end
    n_checks++; if (rs1_v !== 32'd0) begin n_fail++; $display("FAIL reset_rs1v: got %h expected 0", rs1_v); end
    n_checks++; if (mult_div_instr_in !== 32'd0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", mult_div_instr_in); end
    step();
    n_checks++; if (mult_div_en !== 1'b0) begin n_fail++; $display("FAIL reset_no_entry: got %b expected 0", mult_div_en); end
  endtask

  task automatic test_dispatch();
    dispatch_one(32'h0220E1B3, 3'd1, 1'b1, 3'd0, 32'd4, 1'b1, 3'd0, 32'hFFFFFFFD);
    n_checks++; if (mult_div_en !== 1'b0) begin n_fail++; $display("FAIL disp_lat1: got %b expected 0", mult_div_en); end
    step();
    n_checks++; if (mult_div_en !== 1'b1) begin n_fail++; $display("FAIL disp_en: got %b expected 1", mult_div_en); end
    n_checks++; if (rs1_v !== 32'd4) begin n_fail++; $display("FAIL disp_rs1v: got %h expected 4", rs1_v); end
    n_checks++; if (rs2_v !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL disp_rs2v: got %h expected fffffffd", rs2_v); end
    n_checks++; if (rob_tag !== 3'd1) begin n_fail++; $display("FAIL disp_tag: got %0d expected 1", rob_tag); end
    n_checks++; if (mult_div_instr_in !== 32'h0220E1B3) begin n_fail++; $display("FAIL disp_instr: got %h expected 0220e1b3", mult_div_instr_in); end
  endtask

  task automatic test_back_to_back();
    dispatch_one(32'h022081B3, 3'd3, 1'b1, 3'd0, 32'd5, 1'b1, 3'd0, 32'd2);
    n_checks++; if (mult_div_en !== 1'b0) begin n_fail++; $display("FAIL b2b_wait0: got %b expected 0", mult_div_en); end
    step();
    n_checks++; if (mult_div_en !== 1'b0) begin n_fail++; $display("FAIL b2b_wait1: got %b expected 0", mult_div_en); end
    step();
    n_checks++; if (mult_div_en !== 1'b0) begin n_fail++; $display("FAIL b2b_wait2: got %b expected 0", mult_div_en); end
    pulse_resp();
    n_checks++; if (mult_div_en !== 1'b1) begin n_fail++; $display("FAIL b2b_en: got %b expected 1", mult_div_en); end
    n_checks++; if (rob_tag !== 3'd3) begin n_fail++; $display("FAIL b2b_tag: got %0d expected 3", rob_tag); end
    n_checks++; if (rs1_v !== 32'd5) begin n_fail++; $display("FAIL b2b_rs1v: got %h expected 5", rs1_v); end
    n_checks++; if (rs2_v !== 32'd2) begin n_fail++; $display("FAIL b2b_rs2v: got %h expected 2", rs2_v); end
    step();
    n_checks++; if (mult_div_en !== 1'b0) begin n_fail++; $display("FAIL b2b_strobe: got %b expected 0", mult_div_en); end
    n_checks++; if (rob_tag !== 3'd3) begin n_fail++; $display("FAIL b2b_hold: got %0d expected 3", rob_tag); end
    pulse_resp();
    n_checks++; if (mult_div_en !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b expected 0", mult_div_en); end
  endtask

  task automatic test_cdb_wakeup();
    dispatch_one(32'h0220C1B3, 3'd4, 1'b1, 3'd0, 32'd9, 1'b0, 3'd5, 32'd0);
    n_checks++; if (mult_div_en !== 1'b0) begin n_fail++; $display("FAIL wake_wait0: got %b expected 0", mult_div_en); end
    step();
    n_checks++; if (mult_div_en !== 1'b0) begin n_fail++; $display("FAIL wake_wait1: got %b expected 0", mult_div_en); end
    cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 32'h7;
    step();
    cdb_valid = 1'b0;
`ifndef MDRS_CDB_ISSUE_BYPASS_EN
    n_checks++; if (mult_div_en !== 1'b0) begin n_fail++; $display("FAIL wake_nobypass: got %b expected 0", mult_div_en); end
    step();
`endif
    n_checks++; if (mult_div_en !== 1'b1) begin n_fail++; $display("FAIL wake_en: got %b expected 1", mult_div_en); end
    n_checks++; if (rs2_v !== 32'h7) begin n_fail++; $display("FAIL wake_rs2v: got %h expected 7", rs2_v); end
    n_checks++; if (rs1_v !== 32'd9) begin n_fail++; $display("FAIL wake_rs1v: got %h expected 9", rs1_v); end
    n_checks++; if (rob_tag !== 3'd4) begin n_fail++; $display("FAIL wake_tag: got %0d expected 4", rob_tag); end
    pulse_resp();
  endtask

  task automatic test_full_order();
    dispatch_one(32'h02208233, 3'd6, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 32'd1);
    step();
    n_checks++; if (rob_tag !== 3'd6 || mult_div_en !== 1'b1) begin n_fail++; $display("FAIL full_blocker: got tag %0d en %b expected tag 6 en 1", rob_tag, mult_div_en); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (rs_full !== 1'b0) begin n_fail++; $display("FAIL full_early%0d: got %b expected 0", k, rs_full); end
      dispatch_one(32'h02208233, 3'(k), 1'b1, 3'd0, 32'(k), 1'b1, 3'd0, 32'd1);
    end
    n_checks++; if (rs_full !== 1'b1) begin n_fail++; $display("FAIL full_set: got %b expected 1", rs_full); end
    dispatch_one(32'h02208233, 3'd7, 1'b1, 3'd0, 32'd7, 1'b1, 3'd0, 32'd1);
    n_checks++; if (rs_full !== 1'b1) begin n_fail++; $display("FAIL full_drop: got %b expected 1", rs_full); end
    pulse_resp();
    n_checks++; if (mult_div_en !== 1'b1 || rob_tag !== 3'd0) begin n_fail++; $display("FAIL order0: got tag %0d en %b expected tag 0 en 1", rob_tag, mult_div_en); end
    n_checks++; if (rs_full !== 1'b0) begin n_fail++; $display("FAIL full_clear: got %b expected 0", rs_full); end
    // Tag 4 lands in slot 0 but is the youngest entry.
    dispatch_one(32'h02208233, 3'd4, 1'b1, 3'd0, 32'd4, 1'b1, 3'd0, 32'd1);
    for (int k = 1; k < 5; k++) begin
      pulse_resp();
      n_checks++; if (mult_div_en !== 1'b1 || rob_tag !== 3'(k)) begin n_fail++; $display("FAIL order%0d: got tag %0d en %b expected tag %0d en 1", k, rob_tag, mult_div_en, k); end
    end
    pulse_resp();
    n_checks++; if (mult_div_en !== 1'b0) begin n_fail++; $display("FAIL full_dropped_issued: got %b tag %0d expected en 0", mult_div_en, rob_tag); end
    step();
    n_checks++; if (mult_div_en !== 1'b0 || rs_full !== 1'b0) begin n_fail++; $display("FAIL full_empty: got en %b full %b expected 0 0", mult_div_en, rs_full); end
  endtask

  task automatic test_same_cycle_cdb();
    cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 32'h11;
    dispatch_one(32'h0220D1B3, 3'd5, 1'b0, 3'd2, 32'd0, 1'b1, 3'd0, 32'd3);
    cdb_valid = 1'b0;
    n_checks++; if (mult_div_en !== 1'b0) begin n_fail++; $display("FAIL samecdb_lat: got %b expected 0", mult_div_en); end
    step();
    n_checks++; if (mult_div_en !== 1'b1) begin n_fail++; $display("FAIL samecdb_en: got %b expected 1", mult_div_en); end
    n_checks++; if (rs1_v !== 32'h11) begin n_fail++; $display("FAIL samecdb_rs1v: got %h expected 11", rs1_v); end
    n_checks++; if (rs2_v !== 32'd3) begin n_fail++; $display("FAIL samecdb_rs2v: got %h expected 3", rs2_v); end
    pulse_resp();
  endtask

  task automatic test_flush();
    dispatch_one(32'h02208233, 3'd7, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 32'd1);
    for (int k = 1; k < 4; k++)
      dispatch_one(32'h02208233, 3'(k), 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_checks++; if (rs_full !== 1'b0) begin n_fail++; $display("FAIL flush_full: got %b expected 0", rs_full); end
    n_checks++; if (mult_div_en !== 1'b0) begin n_fail++; $display("FAIL flush_noissue: got %b expected 0", mult_div_en); end
    // Busy survives the flush, so this entry must wait for the response.
    dispatch_one(32'h02208233, 3'd6, 1'b1, 3'd0, 32'h21, 1'b1, 3'd0, 32'h22);
    step();
    n_checks++; if (mult_div_en !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", mult_div_en); end
    pulse_resp();
    n_checks++; if (mult_div_en !== 1'b1 || rob_tag !== 3'd6) begin n_fail++; $display("FAIL flush_next: got tag %0d en %b expected tag 6 en 1", rob_tag, mult_div_en); end
    n_checks++; if (rs1_v !== 32'h21) begin n_fail++; $display("FAIL flush_rs1v: got %h expected 21", rs1_v); end
    pulse_resp();
  endtask

  task automatic test_reset_midop();
    dispatch_one(32'h02208233, 3'd2, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 32'd1);
    dispatch_one(32'h02208233, 3'd3, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 32'd1);
    rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0;
    n_checks++; if (rob_tag !== 3'd0 || rs1_v !== 32'd0 || mult_div_en !== 1'b0) begin n_fail++; $display("FAIL midrst_out: got tag %0d rs1v %h en %b expected 0 0 0", rob_tag, rs1_v, mult_div_en); end
    pulse_resp();
    dispatch_one(32'h02208233, 3'd5, 1'b1, 3'd0, 32'd8, 1'b1, 3'd0, 32'd1);
    step();
    n_checks++; if (mult_div_en !== 1'b1 || rob_tag !== 3'd5) begin n_fail++; $display("FAIL midrst_issue: got tag %0d en %b expected tag 5 en 1", rob_tag, mult_div_en); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; dispatch_valid = 1'b0;
    dispatch_instr = '0; dispatch_rob_tag = '0;
    rs1_ready = 1'b0; rs2_ready = 1'b0; rs1_tag = '0; rs2_tag = '0;
    rs1_data = '0; rs2_data = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    mult_div_resp = 1'b0;
    test_reset();
    test_dispatch();
    test_back_to_back();
    test_cdb_wakeup();
    test_full_order();
    test_same_cycle_cdb();
    test_flush();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_div_rs.md
MULT_DIV_RS -- requirements
Module: mult_div_rs

Interface
REQ-001 The module SHALL have parameter RS_DEPTH, default 4, giving the number of reservation entries (2..8).
REQ-002 The module SHALL have parameter ROB_DEPTH, default 8; TAGW = $clog2(ROB_DEPTH) gives the tag width.
REQ-003 Ports SHALL be exactly as follows:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- flush  in  1  squash all waiting entries.
- dispatch_valid  in  1  dispatch request.
- dispatch_instr  in  32  RV32M instruction word.
- dispatch_rob_tag  in  TAGW  destination ROB tag.
- rs1_ready / rs2_ready  in  1  operand value valid.
- rs1_tag / rs2_tag  in  TAGW  producer tag when the operand is not ready.
- rs1_data / rs2_data  in  32  operand value when ready.
- rs_full  out  1  no free entry.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAGW  CDB broadcast tag.
- cdb_data  in  32  CDB broadcast value.
- mult_div_instr_in  out  32  instruction to the mult_div unit.
- rs1_v / rs2_v  out  32  operand values to the mult_div unit.
- rob_tag  out  TAGW  destination tag to the mult_div unit.
- mult_div_en  out  1  one-cycle issue strobe.
- mult_div_resp  in  1  mult_div unit completed its operation.

Function
REQ-004 Entry state SHALL be: valid, instr, dest tag, and for each operand a ready bit, a tag and a 32-bit value.
REQ-005 rs_full SHALL be combinational and SHALL be 1 exactly when all RS_DEPTH entries are valid.
- rs_full SHALL NOT account for an issue in the same cycle.
- A dispatch with rs_full=1 SHALL be ignored.
REQ-006 When dispatch_valid=1 and rs_full=0, the module SHALL write the lowest-index free entry on the next edge.
REQ-007 Dispatch capture:
- If an operand is not ready, and cdb_valid=1 with cdb_tag equal to that operand's tag in the dispatch cycle, the entry SHALL store the operand as ready with value cdb_data.
REQ-008 CDB wakeup:
- Each cycle with cdb_valid=1, every valid entry with an unready operand whose tag equals cdb_tag SHALL set that ready bit and latch cdb_data.
- This covers both operands of the same entry.
REQ-009 A busy flag SHALL be set on issue and cleared on the edge where mult_div_resp=1, unless a new issue occurs in that same cycle.
REQ-010 Issue conditions: an issue SHALL occur when (busy=0 or mult_div_resp=1) and at least one entry is eligible.
- The entry chosen SHALL be the oldest eligible entry by dispatch order.
- Age SHALL be tracked, not inferred from index.
REQ-011 On issue, the registered outputs SHALL take the chosen entry's contents on the next edge, mult_div_en SHALL be 1 for exactly that one cycle, and the entry SHALL be freed on the same edge.
REQ-012 The outputs mult_div_instr_in, rs1_v, rs2_v and rob_tag SHALL hold their values until the next issue.
REQ-013 Dispatch-to-issue latency SHALL be at minimum 2 cycles:
- Edge 1 writes the entry.
- Edge 2 presents it with mult_div_en=1.
REQ-014 A freed entry SHALL be reusable by a dispatch in the cycle after it is freed.
REQ-015 Flush:
- flush=1 SHALL invalidate all entries on the next edge.
- It SHALL suppress issue and dispatch in that cycle.
- It SHALL NOT clear busy; an in-flight operation completes and clears busy via mult_div_resp.
REQ-016 If flush and rst are both asserted, rst SHALL take precedence.

Reset
REQ-017 While rst=1, on each edge, all entries SHALL become invalid, busy SHALL become 0, mult_div_en SHALL become 0, and mult_div_instr_in, rs1_v, rs2_v and rob_tag SHALL become 0.
REQ-018 Reset asserted mid-operation SHALL abandon the in-flight operation, and any mult_div_resp seen while busy=0 SHALL be ignored.

Configuration
REQ-019 Macro MDRS_CDB_ISSUE_BYPASS_EN defined:
- An entry whose last unready operand(s) match the current CDB broadcast SHALL be eligible for issue that same cycle.
- The forwarded operand SHALL be driven from cdb_data, saving one cycle.
REQ-020 Macro MDRS_CDB_ISSUE_BYPASS_EN undefined:
- Only entries whose ready bits are already both 1 at the start of the cycle SHALL be eligible.

Verification
REQ-021 Reset and dispatch:
- Stimulus: reset, then dispatch instr 0x0220E1B3 (rem x3,x1,x2), tag 1, rs1=4 ready, rs2=0xFFFFFFFD ready.
- Response: mult_div_en=1 two cycles after dispatch, with rs1_v=4, rs2_v=0xFFFFFFFD and rob_tag=1.
REQ-022 Back-to-back issue:
- Stimulus: a second dispatch of 0x022081B3, tag 3, operands 5 and 2, while busy.
- Response: no issue until mult_div_resp=1; issue occurs in the cycle after resp with rob_tag=3.
REQ-023 CDB wakeup:
- Stimulus: dispatch with rs2 unready, tag 5; CDB later broadcasts tag 5, data 0x00000007.
- Response: issue with rs2_v=0x00000007.
- Latency from the broadcast: 1 cycle with the macro defined, 2 cycles without.
REQ-024 Full / ordering:
- Stimulus: dispatch 4 entries with tags 0-3 while busy.
- Response: rs_full=1 and a fifth dispatch is dropped; after successive resp pulses the issue order is 0, 1, 2, 3.
REQ-025 Same-cycle CDB at dispatch:
- Stimulus: dispatch with rs1 unready, tag 2, while the CDB broadcasts tag 2, data 0x11.
- Response: the entry issues with rs1_v=0x11.
REQ-026 Flush:
- Stimulus: flush with 3 entries waiting and one operation in flight.
- Response: no further issue; busy clears on resp; rs_full=0; the next dispatch issues normally.
